// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: config handshake between a config master and clk_div_ctrl
//   cfg_valid : master -> controller, request valid
//   cfg_half  : master -> controller, requested half-period (0 is illegal)
//   cfg_ready : controller -> master, request can be accepted
//   cfg_err   : controller -> master, one-cycle pulse on a rejected H=0 request
interface clk_div_ctrl_if #(parameter int CNT_W = 8);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             cfg_err;
   modport master (output cfg_valid, cfg_half, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable 50%-duty clock divider with glitch-free ratio updates
//   clk, rst   : system clock, synchronous active-high reset
//   en         : run request, sampled only at the end of a full output period
//   cfg        : clk_div_ctrl_if slave (cfg_valid/cfg_half in, cfg_ready/cfg_err out)
//   clk_out    : registered divided clock, period 2*H clk cycles
//   tick       : one-cycle pulse in the cycle clk_out rises
//   running    : high while dividing (RUN or PEND)
//   period_cnt : completed output periods, present only with CLK_DIV_CTRL_PCNT_EN
module clk_div_ctrl #(
   parameter int CNT_W    = 8,
   parameter int DEF_HALF = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   clk_div_ctrl_if.slave cfg,
   output logic          clk_out,
   output logic          tick,
   output logic          running
`ifdef CLK_DIV_CTRL_PCNT_EN
   ,
   output logic [15:0]   period_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, pend_q, pend_d;
   logic             clk_q, clk_d, tick_q, tick_d, err_q, err_d;
   logic             accept, legal, toggle, fall;
`ifdef CLK_DIV_CTRL_PCNT_EN
   logic [15:0]      pcnt_q, pcnt_d;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         half_q  <= CNT_W'(DEF_HALF);
         pend_q  <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_PCNT_EN
         pcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         err_q   <= err_d;
`ifdef CLK_DIV_CTRL_PCNT_EN
         pcnt_q  <= pcnt_d;
`endif
      end
   end
   always_comb begin
      accept  = cfg.cfg_valid & cfg.cfg_ready;
      legal   = accept & (cfg.cfg_half != '0);
      toggle  = (state_q != IDLE) & (cnt_q == half_q - 1'b1);
      // fall marks the end of a full output period: the only point where
      // ratio changes and stops may take effect
      fall    = toggle & clk_q;
      state_d = state_q;
      cnt_d   = toggle ? '0 : cnt_q + 1'b1;
      half_d  = half_q;
      pend_d  = pend_q;
      clk_d   = clk_q ^ toggle;
      tick_d  = toggle & ~clk_q;
      err_d   = accept & (cfg.cfg_half == '0);
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            half_d  = legal ? cfg.cfg_half : half_q;
            state_d = en ? RUN : IDLE;
         end
         RUN: begin
            if (fall & ~en) begin
               // stopping: nothing remains to wait for, so a same-cycle config lands directly
               state_d = IDLE;
               half_d  = legal ? cfg.cfg_half : half_q;
            end else if (legal) begin
               pend_d  = cfg.cfg_half;
               state_d = PEND;
            end
         end
         PEND: begin
            if (fall) begin
               half_d  = pend_q;
               state_d = en ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef CLK_DIV_CTRL_PCNT_EN
      pcnt_d = (state_q == IDLE) ? (en ? 16'd0 : pcnt_q) : pcnt_q + 16'(fall);
`endif
   end
   always_comb begin
      cfg.cfg_ready = state_q != PEND;
      cfg.cfg_err   = err_q;
      running       = state_q != IDLE;
      clk_out       = clk_q;
      tick          = tick_q;
`ifdef CLK_DIV_CTRL_PCNT_EN
      period_cnt    = pcnt_q;
`endif
   end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic clk_out, tick, running;
`ifdef CLK_DIV_CTRL_PCNT_EN
   logic [15:0] period_cnt;
`endif
   int n_cmp = 0;
   int n_bad = 0;
   clk_div_ctrl_if #(.CNT_W(8)) cfg ();
   clk_div_ctrl #(.CNT_W(8), .DEF_HALF(2)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg(cfg),
      .clk_out(clk_out), .tick(tick), .running(running)
`ifdef CLK_DIV_CTRL_PCNT_EN
      , .period_cnt(period_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // j counts edges since the start of a low phase with half-period h
   task automatic wave(input int j0, input int j1, input int h);
      for (int j = j0; j < j1; j++) begin
         step();
         chk("clk_out", clk_out, 32'((j / h) & 1));
         chk("tick", tick, 32'(((j / h) & 1) == 1 && (j % h) == 0));
         chk("running", running, 1);
      end
   endtask
   task automatic chk_reset();
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_err", cfg.cfg_err, 0);
      chk("rst_ready", cfg.cfg_ready, 1);
      chk("rst_running", running, 0);
`ifdef CLK_DIV_CTRL_PCNT_EN
      chk("rst_pcnt", period_cnt, 0);
`endif
   endtask
   initial begin
      cfg.cfg_valid = 1'b0;
      cfg.cfg_half  = '0;
      step();
      step();
      chk_reset();
      // default H=2 from reset
      rst = 1'b0;
      en  = 1'b1;
      wave(0, 7, 2);
      // accept H=5 in the first high cycle
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd5;
      step();
      chk("pend_clk", clk_out, 1);
      chk("pend_ready", cfg.cfg_ready, 0);
      chk("pend_running", running, 1);
      cfg.cfg_valid = 1'b0;
      step();
      chk("switch_clk", clk_out, 0);
      chk("switch_ready", cfg.cfg_ready, 1);
      wave(1, 15, 5);
      // illegal H=0
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd0;
      wave(15, 16, 5);
      chk("err_pulse", cfg.cfg_err, 1);
      chk("err_ready", cfg.cfg_ready, 1);
      cfg.cfg_valid = 1'b0;
      wave(16, 17, 5);
      chk("err_clear", cfg.cfg_err, 0);
      wave(17, 27, 5);
      // drop en inside the high phase: phase still completes
      en = 1'b0;
      wave(27, 30, 5);
      step();
      chk("stop5_clk", clk_out, 0);
      chk("stop5_running", running, 0);
      step();
      chk("idle_clk", clk_out, 0);
      // H=1 accepted in IDLE together with en
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd1;
      en            = 1'b1;
      wave(0, 1, 1);
      cfg.cfg_valid = 1'b0;
      chk("h1_ready", cfg.cfg_ready, 1);
      wave(1, 8, 1);
      // switch to H=3 at the end of the period
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd3;
      step();
      chk("h3_acc_clk", clk_out, 0);
      chk("h3_acc_ready", cfg.cfg_ready, 0);
      cfg.cfg_valid = 1'b0;
      step();
      chk("h3_last_clk", clk_out, 1);
      chk("h3_last_tick", tick, 1);
      step();
      chk("h3_sw_clk", clk_out, 0);
      chk("h3_sw_ready", cfg.cfg_ready, 1);
      wave(1, 4, 3);
      en = 1'b0;
      wave(4, 6, 3);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stop3_clk", clk_out, 0);
         chk("stop3_running", running, 0);
         chk("stop3_tick", tick, 0);
      end
      // reset while H=4 running with 7 pending
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd4;
      step();
      chk("idle_ld_ready", cfg.cfg_ready, 1);
      chk("idle_ld_running", running, 0);
      cfg.cfg_valid = 1'b0;
      en = 1'b1;
      step();
      chk("h4_running", running, 1);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_half  = 8'd7;
      step();
      chk("h4_pend_ready", cfg.cfg_ready, 0);
      cfg.cfg_valid = 1'b0;
      step();
      chk("h4_clk", clk_out, 0);
      rst = 1'b1;
      step();
      chk_reset();
      rst = 1'b0;
      wave(0, 13, 2);
      chk("post_rst_ready", cfg.cfg_ready, 1);
`ifdef CLK_DIV_CTRL_PCNT_EN
      chk("pcnt3", period_cnt, 3);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
